// File: rtl/flop_dbg_pkg.sv
// Shared definitions for the flop debug read path: FSM encoding,
// chunk-count and index-width helpers, saturating increment.
package flop_dbg_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } snap_state_e;

   // Number of OUT_W-bit chunks needed to cover a STATE_W-bit vector.
   function automatic int num_chunks(input int state_w, input int out_w);
      return (state_w + out_w - 1) / out_w;
   endfunction

   // Width of a chunk index; a single-chunk vector still gets one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Increment value, clamping at the all-ones value of a width-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? max_val : (value + 32'd1);
   endfunction

endpackage

// File: rtl/flop_chunk_select.sv
// Combinational chunk mux: zero-pads the shadow vector up to a whole
// number of chunks and selects chunk number idx.
module flop_chunk_select
   import flop_dbg_pkg::*;
#(
   parameter  int STATE_W    = 64,
   parameter  int OUT_W      = 8,
   localparam int NUM_CHUNKS = num_chunks(STATE_W, OUT_W),
   localparam int IDX_W      = idx_width(NUM_CHUNKS)
) (
   input  logic [STATE_W-1:0] shadow,
   input  logic [IDX_W-1:0]   idx,
   output logic [OUT_W-1:0]   chunk
);

   localparam int PAD_W = NUM_CHUNKS * OUT_W;

   logic [PAD_W-1:0] w_padded;
   logic [OUT_W-1:0] w_chunks [NUM_CHUNKS];

   // Bits above STATE_W-1 in the final chunk read as zero.
   assign w_padded = PAD_W'(shadow);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
         assign w_chunks[gi] = w_padded[gi*OUT_W +: OUT_W];
      end
   endgenerate

   // Select the indexed chunk; an out-of-range index yields zero.
   always_comb begin
      chunk = '0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
         if (idx == IDX_W'(i)) begin
            chunk = w_chunks[i];
         end
      end
   end

endmodule

// File: rtl/flop_snapshot_reader.sv
// Captures a snapshot of a live flop state vector on request and streams
// it out LSB-first as OUT_W-bit chunks over a valid/ready interface.
// Requests arriving while a stream is in flight are dropped and counted.
module flop_snapshot_reader
   import flop_dbg_pkg::*;
#(
   parameter  int STATE_W    = 64,
   parameter  int OUT_W      = 8,
   parameter  int DROP_W     = 8,
   localparam int NUM_CHUNKS = num_chunks(STATE_W, OUT_W),
   localparam int IDX_W      = idx_width(NUM_CHUNKS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               snap_req,
   input  logic [STATE_W-1:0] state_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   output logic               busy,
   output logic               snap_done,
   output logic               snap_drop,
   output logic [DROP_W-1:0]  drop_cnt
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   snap_state_e         r_state;
   snap_state_e         w_state_next;
   logic [STATE_W-1:0]  r_shadow;
   logic [STATE_W-1:0]  w_shadow_next;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_next;
   logic                r_done;
   logic                w_done_next;
   logic                r_drop;
   logic                w_drop_next;
   logic [DROP_W-1:0]   r_drop_cnt;
   logic [DROP_W-1:0]   w_drop_cnt_next;
   logic [OUT_W-1:0]    w_chunk;
   logic                w_sending;

   assign w_sending = (r_state == ST_SEND);

   flop_chunk_select #(
      .STATE_W (STATE_W),
      .OUT_W   (OUT_W)
   ) u_chunk_select (
      .shadow (r_shadow),
      .idx    (r_idx),
      .chunk  (w_chunk)
   );

   // State, shadow, index and status registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_shadow   <= '0;
         r_idx      <= '0;
         r_done     <= 1'b0;
         r_drop     <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_shadow   <= w_shadow_next;
         r_idx      <= w_idx_next;
         r_done     <= w_done_next;
         r_drop     <= w_drop_next;
         r_drop_cnt <= w_drop_cnt_next;
      end
   end

   // Next-state logic: capture in IDLE, advance on handshake in SEND,
   // and count any request that arrives while a stream is active.
   always_comb begin
      w_state_next    = r_state;
      w_shadow_next   = r_shadow;
      w_idx_next      = r_idx;
      w_done_next     = 1'b0;
      w_drop_next     = 1'b0;
      w_drop_cnt_next = r_drop_cnt;

      case (r_state)
         ST_IDLE: begin
            if (snap_req) begin
               w_shadow_next = state_in;
               w_idx_next    = '0;
               w_state_next  = ST_SEND;
            end
         end
         ST_SEND: begin
            // A request during the final handshake is still rejected.
            if (snap_req) begin
               w_drop_next     = 1'b1;
               w_drop_cnt_next = DROP_W'(sat_inc(32'(r_drop_cnt), DROP_W));
            end
            if (out_ready) begin
               if (r_idx == LAST_IDX) begin
                  w_state_next = ST_IDLE;
                  w_idx_next   = '0;
                  w_done_next  = 1'b1;
               end else begin
                  w_idx_next = r_idx + IDX_W'(1);
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs come straight from registers, so they are stable while stalled.
   assign out_valid = w_sending;
   assign busy      = w_sending;
   assign out_data  = w_sending ? w_chunk : '0;
   assign out_idx   = r_idx;
   assign out_last  = w_sending && (r_idx == LAST_IDX);
   assign snap_done = r_done;
   assign snap_drop = r_drop;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_flop_snapshot_reader.sv
// Self-checking bench: directed scenarios on a 20-bit/3-chunk instance and
// an 8-bit/1-chunk instance, plus a randomized run against a snapshot model.
module tb_flop_snapshot_reader;

   localparam int SW = 20;
   localparam int OW = 8;
   localparam int DW = 8;
   localparam int NC = 3;
   localparam int IW = 2;

   localparam int SW1 = 8;
   localparam int OW1 = 8;
   localparam int DW1 = 2;
   localparam int IW1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: 20-bit state, 3 chunks
   logic          rst;
   logic          snap_req;
   logic [SW-1:0] state_in;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic          busy;
   logic          snap_done;
   logic          snap_drop;
   logic [DW-1:0] drop_cnt;

   // instance B: 8-bit state, single chunk, 2-bit drop counter
   logic           rst_b;
   logic           snap_req_b;
   logic [SW1-1:0] state_in_b;
   logic           out_valid_b;
   logic           out_ready_b;
   logic [OW1-1:0] out_data_b;
   logic [IW1-1:0] out_idx_b;
   logic           out_last_b;
   logic           busy_b;
   logic           snap_done_b;
   logic           snap_drop_b;
   logic [DW1-1:0] drop_cnt_b;

   int total = 0;
   int bad   = 0;

   flop_snapshot_reader #(.STATE_W(SW), .OUT_W(OW), .DROP_W(DW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .snap_req  (snap_req),
      .state_in  (state_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .snap_done (snap_done),
      .snap_drop (snap_drop),
      .drop_cnt  (drop_cnt)
   );

   flop_snapshot_reader #(.STATE_W(SW1), .OUT_W(OW1), .DROP_W(DW1)) u_dut_b (
      .clk       (clk),
      .rst       (rst_b),
      .snap_req  (snap_req_b),
      .state_in  (state_in_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .out_data  (out_data_b),
      .out_idx   (out_idx_b),
      .out_last  (out_last_b),
      .busy      (busy_b),
      .snap_done (snap_done_b),
      .snap_drop (snap_drop_b),
      .drop_cnt  (drop_cnt_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; snap_req = 1'b0; out_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic do_reset_b();
      rst_b = 1'b1; snap_req_b = 1'b0; out_ready_b = 1'b0;
      step();
      rst_b = 1'b0;
   endtask

   task automatic test_reset();
      state_in = 20'hFFFFF; state_in_b = 8'hFF;
      out_ready = 1'b1; out_ready_b = 1'b1;
      rst = 1'b1; rst_b = 1'b1; snap_req = 1'b1; snap_req_b = 1'b1;
      step();
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
      total++; if (out_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", out_idx); end
      total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
      total++; if ({snap_done, snap_drop} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {snap_done, snap_drop}); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_dropcnt got=%0d want=0", drop_cnt); end
      total++; if ({out_valid_b, busy_b, drop_cnt_b} !== 4'b0000) begin bad++; $display("FAIL reset_b got=%b want=0000", {out_valid_b, busy_b, drop_cnt_b}); end
      rst = 1'b0; rst_b = 1'b0; snap_req = 1'b0; snap_req_b = 1'b0;
      out_ready = 1'b0; out_ready_b = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic_stream();
      logic [OW-1:0] exp_c [NC];
      exp_c[0] = 8'hDE; exp_c[1] = 8'hBC; exp_c[2] = 8'h0A;
      do_reset();
      state_in = 20'hABCDE; snap_req = 1'b1; out_ready = 1'b1;
      step();
      snap_req = 1'b0;
      for (int k = 0; k < NC; k++) begin
         total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL basic_valid%0d got=%b%b want=11", k, out_valid, busy); end
         total++; if (out_data !== exp_c[k]) begin bad++; $display("FAIL basic_data%0d got=%h want=%h", k, out_data, exp_c[k]); end
         total++; if (out_idx !== IW'(k)) begin bad++; $display("FAIL basic_idx%0d got=%0d want=%0d", k, out_idx, k); end
         total++; if (out_last !== (k == NC-1)) begin bad++; $display("FAIL basic_last%0d got=%b want=%b", k, out_last, (k == NC-1)); end
         total++; if (snap_done !== 1'b0) begin bad++; $display("FAIL basic_early_done%0d got=%b want=0", k, snap_done); end
         step();
      end
      total++; if (snap_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", snap_done); end
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b%b want=00", out_valid, busy); end
      step();
      total++; if (snap_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", snap_done); end
      out_ready = 1'b0;
      $display("test_basic_stream done");
   endtask

   task automatic test_stall();
      do_reset();
      state_in = 20'hABCDE; snap_req = 1'b1; out_ready = 1'b1;
      step();
      snap_req = 1'b0;
      step();
      out_ready = 1'b0; state_in = 20'h12345;
      for (int s = 0; s < 3; s++) begin
         step();
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d got=%b want=1", s, out_valid); end
         total++; if (out_data !== 8'hBC || out_idx !== 2'd1) begin bad++; $display("FAIL stall_hold%0d got=%h/%0d want=bc/1", s, out_data, out_idx); end
      end
      out_ready = 1'b1;
      step();
      total++; if (out_data !== 8'h0A || out_last !== 1'b1) begin bad++; $display("FAIL stall_chunk2 got=%h/%b want=0a/1", out_data, out_last); end
      step();
      total++; if (snap_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", snap_done); end
      out_ready = 1'b0;
      $display("test_stall done");
   endtask

   task automatic test_held_request();
      do_reset();
      state_in = 20'hABCDE; snap_req = 1'b1; out_ready = 1'b0;
      step();
      total++; if (out_valid !== 1'b1 || snap_drop !== 1'b0) begin bad++; $display("FAIL held_first got=%b%b want=10", out_valid, snap_drop); end
      state_in = 20'h00000;
      for (int i = 1; i <= 4; i++) begin
         step();
         total++; if (snap_drop !== 1'b1) begin bad++; $display("FAIL held_drop%0d got=%b want=1", i, snap_drop); end
         total++; if (drop_cnt !== DW'(i)) begin bad++; $display("FAIL held_cnt%0d got=%0d want=%0d", i, drop_cnt, i); end
         total++; if (out_data !== 8'hDE || out_idx !== 2'd0) begin bad++; $display("FAIL held_chunk%0d got=%h/%0d want=de/0", i, out_data, out_idx); end
      end
      snap_req = 1'b0; out_ready = 1'b1;
      step();
      total++; if (snap_drop !== 1'b0 || drop_cnt !== 8'd4) begin bad++; $display("FAIL held_after got=%b/%0d want=0/4", snap_drop, drop_cnt); end
      total++; if (out_data !== 8'hBC) begin bad++; $display("FAIL held_c1 got=%h want=bc", out_data); end
      step();
      total++; if (out_data !== 8'h0A) begin bad++; $display("FAIL held_c2 got=%h want=0a", out_data); end
      step();
      total++; if (snap_done !== 1'b1) begin bad++; $display("FAIL held_done got=%b want=1", snap_done); end
      out_ready = 1'b0;
      $display("test_held_request done");
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      state_in = 20'hABCDE; snap_req = 1'b1; out_ready = 1'b0;
      step();
      step();
      snap_req = 1'b0;
      total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL midrst_precnt got=%0d want=1", drop_cnt); end
      out_ready = 1'b1;
      step();
      total++; if (out_idx !== 2'd1) begin bad++; $display("FAIL midrst_pre_idx got=%0d want=1", out_idx); end
      rst = 1'b1; out_ready = 1'b0;
      step();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b%b want=00", out_valid, busy); end
      total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", drop_cnt); end
      total++; if (out_idx !== 2'd0 || out_data !== 8'h00) begin bad++; $display("FAIL midrst_out got=%0d/%h want=0/00", out_idx, out_data); end
      for (int s = 0; s < 3; s++) begin
         total++; if (snap_done !== 1'b0) begin bad++; $display("FAIL midrst_nodone%0d got=%b want=0", s, snap_done); end
         out_ready = 1'b1;
         step();
      end
      state_in = 20'h12345; snap_req = 1'b1;
      step();
      snap_req = 1'b0;
      total++; if (out_idx !== 2'd0 || out_data !== 8'h45) begin bad++; $display("FAIL midrst_restart got=%0d/%h want=0/45", out_idx, out_data); end
      step();
      total++; if (out_data !== 8'h23) begin bad++; $display("FAIL midrst_c1 got=%h want=23", out_data); end
      step();
      total++; if (out_data !== 8'h01 || out_last !== 1'b1) begin bad++; $display("FAIL midrst_c2 got=%h/%b want=01/1", out_data, out_last); end
      step();
      out_ready = 1'b0;
      $display("test_reset_mid_stream done");
   endtask

   task automatic test_single_chunk();
      do_reset_b();
      state_in_b = 8'h5A; snap_req_b = 1'b1; out_ready_b = 1'b1;
      step();
      snap_req_b = 1'b0; state_in_b = 8'h00;
      total++; if (out_valid_b !== 1'b1 || out_data_b !== 8'h5A) begin bad++; $display("FAIL single_data got=%b/%h want=1/5a", out_valid_b, out_data_b); end
      total++; if (out_last_b !== 1'b1 || out_idx_b !== 1'b0) begin bad++; $display("FAIL single_last got=%b/%0d want=1/0", out_last_b, out_idx_b); end
      step();
      total++; if (snap_done_b !== 1'b1 || out_valid_b !== 1'b0) begin bad++; $display("FAIL single_done got=%b/%b want=1/0", snap_done_b, out_valid_b); end
      state_in_b = 8'hC3; snap_req_b = 1'b1;
      step();
      snap_req_b = 1'b0;
      total++; if (out_valid_b !== 1'b1 || out_data_b !== 8'hC3 || out_last_b !== 1'b1) begin bad++; $display("FAIL single_second got=%b/%h/%b want=1/c3/1", out_valid_b, out_data_b, out_last_b); end
      total++; if (snap_drop_b !== 1'b0 || drop_cnt_b !== 2'd0) begin bad++; $display("FAIL single_nodrop got=%b/%0d want=0/0", snap_drop_b, drop_cnt_b); end
      step();
      total++; if (snap_done_b !== 1'b1) begin bad++; $display("FAIL single_done2 got=%b want=1", snap_done_b); end
      out_ready_b = 1'b0;
      $display("test_single_chunk done");
   endtask

   task automatic test_drop_saturate();
      do_reset_b();
      state_in_b = 8'h77; snap_req_b = 1'b1; out_ready_b = 1'b0;
      step();
      for (int i = 1; i <= 5; i++) begin
         step();
         total++; if (snap_drop_b !== 1'b1) begin bad++; $display("FAIL sat_drop%0d got=%b want=1", i, snap_drop_b); end
         total++; if (drop_cnt_b !== DW1'((i > 3) ? 3 : i)) begin bad++; $display("FAIL sat_cnt%0d got=%0d want=%0d", i, drop_cnt_b, (i > 3) ? 3 : i); end
      end
      snap_req_b = 1'b0; out_ready_b = 1'b1;
      step();
      total++; if (snap_done_b !== 1'b1 || drop_cnt_b !== 2'd3) begin bad++; $display("FAIL sat_end got=%b/%0d want=1/3", snap_done_b, drop_cnt_b); end
      out_ready_b = 1'b0;
      $display("test_drop_saturate done");
   endtask

   // Randomized traffic against a snapshot-level model: an active snapshot
   // value, the chunk number currently offered, pending pulses and a drop tally.
   task automatic test_random();
      bit            m_active;
      logic [SW-1:0] m_snap;
      int            m_k;
      bit            m_done;
      bit            m_drop;
      int            m_drops;
      int            snaps;
      logic [31:0]   shifted;
      logic [OW-1:0] exp_data;
      bit            req, rdy, rr;
      logic [SW-1:0] sv;
      do_reset();
      m_active = 0; m_snap = '0; m_k = 0; m_done = 0; m_drop = 0; m_drops = 0; snaps = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         shifted  = 32'(m_snap) >> (m_k * OW);
         exp_data = m_active ? shifted[OW-1:0] : '0;
         total++; if (out_valid !== m_active || busy !== m_active) begin bad++; $display("FAIL rnd_valid c%0d got=%b%b want=%b", cyc, out_valid, busy, m_active); end
         total++; if (out_data !== exp_data) begin bad++; $display("FAIL rnd_data c%0d got=%h want=%h", cyc, out_data, exp_data); end
         total++; if (out_last !== (m_active && m_k == NC-1)) begin bad++; $display("FAIL rnd_last c%0d got=%b want=%b", cyc, out_last, (m_active && m_k == NC-1)); end
         if (m_active) begin
            total++; if (out_idx !== IW'(m_k)) begin bad++; $display("FAIL rnd_idx c%0d got=%0d want=%0d", cyc, out_idx, m_k); end
         end
         total++; if (snap_done !== m_done || snap_drop !== m_drop) begin bad++; $display("FAIL rnd_pulse c%0d got=%b%b want=%b%b", cyc, snap_done, snap_drop, m_done, m_drop); end
         total++; if (drop_cnt !== DW'(m_drops)) begin bad++; $display("FAIL rnd_dropcnt c%0d got=%0d want=%0d", cyc, drop_cnt, m_drops); end
         if (m_done) begin snaps++; $display("random snapshot %0d done at cycle %0d", snaps, cyc); end

         req = ($urandom_range(0, 3) == 0);
         rdy = ($urandom_range(0, 1) == 1);
         rr  = ($urandom_range(0, 99) == 0);
         sv  = SW'($urandom);
         snap_req = req; out_ready = rdy; rst = rr; state_in = sv;

         m_done = 0; m_drop = 0;
         if (rr) begin
            m_active = 0; m_snap = '0; m_k = 0; m_drops = 0;
         end else if (m_active) begin
            if (req) begin
               m_drop = 1;
               if (m_drops < (1 << DW) - 1) m_drops++;
            end
            if (rdy) begin
               if (m_k == NC-1) begin m_active = 0; m_k = 0; m_done = 1; end
               else m_k++;
            end
         end else if (req) begin
            m_active = 1; m_snap = sv; m_k = 0;
         end
         step();
      end
      rst = 1'b0; snap_req = 1'b0; out_ready = 1'b0;
      $display("test_random done (%0d snapshots)", snaps);
   endtask

   initial begin
      rst = 1'b1; rst_b = 1'b1;
      snap_req = 1'b0; snap_req_b = 1'b0;
      out_ready = 1'b0; out_ready_b = 1'b0;
      state_in = '0; state_in_b = '0;
      test_reset();
      test_basic_stream();
      test_stall();
      test_held_request();
      test_reset_mid_stream();
      test_single_chunk();
      test_drop_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/flop_snapshot_reader.md
Name: flop_snapshot_reader

Overview:
- Read-side counterpart to the design's flop storage.
- On request, captures a parallel snapshot of a flop state vector into a shadow register.
- Streams the snapshot out LSB-first in OUT_W-bit chunks over a valid/ready interface.
- Used by the GPU debug/dump path to read live flop state without stopping the clock.

Parameters:
STATE_W, 64, width of the flop state vector being sampled.
OUT_W, 8, width of each output chunk.
DROP_W, 8, width of the saturating dropped-request counter.

Ports:
clk  input  1  single clock; all logic on posedge clk.
rst  input  1  synchronous, active-high reset.
snap_req  input  1  request a snapshot; sampled every cycle.
state_in  input  STATE_W  live flop state vector.
out_valid  output  1  chunk on out_data is valid.
out_ready  input  1  consumer accepts the chunk when high together with out_valid.
out_data  output  OUT_W  current chunk.
out_idx  output  clog2(NUM_CHUNKS) (min 1)  index of the current chunk.
out_last  output  1  current chunk is the final chunk.
busy  output  1  snapshot in progress.
snap_done  output  1  one-cycle pulse after the final chunk is accepted.
snap_drop  output  1  one-cycle pulse when a request was rejected.
drop_cnt  output  DROP_W  saturating count of rejected requests.

Behaviour:
- NUM_CHUNKS = ceil(STATE_W/OUT_W). The final chunk is zero-padded above bit STATE_W-1.
- Reset (rst high at posedge, synchronous active-high): state IDLE, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, snap_done=0, snap_drop=0, drop_cnt=0, shadow register=0.
- FSM states:
  - IDLE:
    - snap_req=1 at posedge: shadow <= state_in (that cycle's value), idx <= 0, go to SEND.
    - In the next cycle: out_valid=1, busy=1, out_data = shadow[OUT_W-1:0].
    - Latency from request to first valid chunk: 1 cycle.
  - SEND:
    - Handshake out_valid&&out_ready: if idx != NUM_CHUNKS-1, idx <= idx+1 and stay in SEND; otherwise go to IDLE, out_valid <= 0, busy <= 0, snap_done <= 1 for one cycle.
    - out_valid&&!out_ready: out_data, out_idx and out_last are held stable. out_valid never drops before acceptance.
    - With out_ready held high, back-to-back chunks go out every cycle. A full snapshot then takes NUM_CHUNKS+1 cycles from request to snap_done.
- Output decoding:
  - out_last = (idx == NUM_CHUNKS-1) && out_valid.
  - out_data = shadow[idx*OUT_W +: OUT_W], padded.
- Rejected requests:
  - snap_req is accepted only in IDLE.
  - snap_req=1 in SEND (including the cycle of the final handshake) causes snap_drop=1 in the next cycle and drop_cnt <= drop_cnt+1, saturating at all-ones.
  - The shadow register is unaffected.
- A request in the cycle snap_done is high: FSM is in IDLE, so it is accepted normally.
- state_in changes after capture have no effect on the current snapshot.
- NUM_CHUNKS=1: the single chunk is both first and last, so out_last=1 on it.
- Reset mid-operation: rst overrides everything, with all outputs at reset values the next cycle. A partially streamed snapshot is abandoned with no snap_done. drop_cnt is cleared.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Shared package flop_dbg_pkg:
  - FSM state encoding (IDLE=0, SEND=1).
  - num_chunks(STATE_W,OUT_W) function.
  - idx-width function (clog2 with min 1).
  - Saturating-increment helper.
- Sub-module flop_chunk_select holds the combinational padded shadow-to-chunk mux, parameterised by STATE_W and OUT_W, with inputs shadow and idx and output chunk.
- FSM, handshake and counters stay in the top module.

Test Plan:
- STATE_W=20, OUT_W=8, state_in=20'hABCDE, snap_req pulse, out_ready=1 → chunks 8'hDE, 8'hBC, 8'h0A on consecutive cycles; out_idx 0,1,2; out_last only on 8'h0A; snap_done pulses 1 cycle later.
- Same config, out_ready low for 3 cycles on chunk 1 → out_data held at 8'hBC, out_idx=1, out_valid=1 throughout. state_in changed to 20'h12345 mid-stream → chunk 2 still 8'h0A.
- snap_req held high for 5 cycles from IDLE → one snapshot. The 4 later cycles each pulse snap_drop, so drop_cnt=4. Stream continues unaffected.
- DROP_W=2, 5 rejected requests → drop_cnt saturates at 2'b11 with no wrap.
- rst asserted during chunk 1 of a 3-chunk stream → next cycle out_valid=0, busy=0, drop_cnt=0, no snap_done. A new snap_req then restarts at out_idx=0 with the fresh state_in.
- STATE_W=8, OUT_W=8, state_in=8'h5A → one chunk 8'h5A with out_last=1. snap_req in the snap_done cycle is accepted and produces a second snapshot.
